// File: rtl/fc_pkg.sv
// Shared constants, FSM state encoding and the round/saturate helper for the
// fully-connected layer. Optional build macro FC_RELU_EN is handled in fc_mac.
package fc_pkg;

    localparam int unsigned N_IN  = 2048;  // flattened input length
    localparam int unsigned N_OUT = 10;    // output neurons
    localparam int unsigned DW    = 20;    // signed Q4.16 data/weight width
    localparam int unsigned FRAC  = 16;    // fraction bits
    localparam int unsigned WAW   = 15;    // weight address width
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned ACC_W = 52;    // product width + 12 guard bits

    localparam logic signed [ACC_W-1:0] SAT_HI = (ACC_W'(1) << (DW - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StBias,
        StRound,
        StWrite,
        StDone
    } state_e;

    // Drop FRAC bits with round-half-up, then clamp to the signed DW-bit range.
    function automatic logic [DW-1:0] round_sat(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] r;
        r = sum >>> FRAC;
        // Separate statement keeps the shift arithmetic; adding the round bit is sign-agnostic.
        r = r + {{(ACC_W-1){1'b0}}, sum[FRAC-1]};
        if (r > SAT_HI) begin
            return SAT_HI[DW-1:0];
        end else if (r < SAT_LO) begin
            return SAT_LO[DW-1:0];
        end
        return r[DW-1:0];
    endfunction

endpackage

// File: rtl/fc_mac.sv
// Datapath for one neuron: registered product, accumulator, bias latch and the
// rounded/saturated result register. Define FC_RELU_EN to clamp negative results to zero.
module fc_mac
    import fc_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          mul_en,   // capture cdata*wdata
    input  logic          clr,      // clear accumulator (first MAC cycle)
    input  logic          en,       // add registered product to accumulator
    input  logic          bias_en,  // latch bias word
    input  logic          rnd_en,   // latch rounded result
    input  logic [DW-1:0] cdata,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] odata
);

    logic signed [PW-1:0]    prod_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [DW-1:0]    bias_q;
    logic [DW-1:0]           res_q;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] sum;
    logic [DW-1:0]           res_d;

    // Align Q4.16 bias with the Q8.32 accumulator and form the rounded result.
    always_comb begin
        bias_ext = {{(ACC_W-DW){bias_q[DW-1]}}, bias_q};
        sum      = acc_q + (bias_ext <<< FRAC);
        res_d    = round_sat(sum);
`ifdef FC_RELU_EN
        if (res_d[DW-1]) begin
            res_d = '0;
        end
`else
`endif
    end

    // Product pipeline register, accumulator, bias and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            acc_q  <= '0;
            bias_q <= '0;
            res_q  <= '0;
        end else begin
            if (mul_en) begin
                prod_q <= $signed(cdata) * $signed(wdata);
            end
            if (clr) begin
                acc_q <= '0;
            end else if (en) begin
                acc_q <= acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
            end
            if (bias_en) begin
                bias_q <= wdata;
            end
            if (rnd_en) begin
                res_q <= res_d;
            end
        end
    end

    assign odata = res_q;

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer: sequences N_OUT dot products over the flatten memory and
// weight ROM, one MAC per clock, and writes each rounded result. Optional macro
// FC_RELU_EN (see fc_mac) zeroes negative results.
module fc_layer
    import fc_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           ready,
    output logic           busy,
    output logic           crd,
    output logic [11:0]    caddr_rd,
    input  logic [DW-1:0]  cdata_rd,
    output logic           wrd,
    output logic [WAW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    output logic           owr,
    output logic [3:0]     oaddr,
    output logic [DW-1:0]  odata
);

    state_e         state_q, state_d;
    logic [11:0]    i_q;     // input index within a neuron
    logic [3:0]     n_q;     // neuron index
    logic [WAW-1:0] base_q;  // first weight address of neuron n_q

    logic last_i;
    logic last_n;

    assign last_i = (i_q == 12'(N_IN - 1));
    assign last_n = (n_q == 4'(N_OUT - 1));

    // Next-state logic and memory/result strobes decoded from the current state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        crd     = 1'b0;
        wrd     = 1'b0;
        owr     = 1'b0;
        waddr   = '0;
        unique case (state_q)
            StIdle, StDone: begin
                if (ready) state_d = StMac;
            end
            StMac: begin
                busy  = 1'b1;
                crd   = 1'b1;
                wrd   = 1'b1;
                waddr = base_q + WAW'(i_q);
                if (last_i) state_d = StBias;
            end
            StBias: begin
                busy    = 1'b1;
                wrd     = 1'b1;
                waddr   = base_q + WAW'(N_IN);
                state_d = StRound;
            end
            StRound: begin
                busy    = 1'b1;
                state_d = StWrite;
            end
            StWrite: begin
                busy    = 1'b1;
                owr     = 1'b1;
                state_d = last_n ? StDone : StMac;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register plus input/neuron/base-address counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            n_q     <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle, StDone: begin
                    if (ready) begin
                        i_q    <= '0;
                        n_q    <= '0;
                        base_q <= '0;
                    end
                end
                StMac: i_q <= last_i ? 12'd0 : i_q + 12'd1;
                StWrite: begin
                    if (!last_n) begin
                        n_q    <= n_q + 4'd1;
                        base_q <= base_q + WAW'(N_IN + 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign caddr_rd = i_q;
    assign oaddr    = n_q;

    fc_mac u_mac (
        .clk     (clk),
        .reset   (reset),
        .mul_en  (state_q == StMac),
        .clr     ((state_q == StMac) && (i_q == 12'd0)),
        .en      (((state_q == StMac) && (i_q != 12'd0)) || (state_q == StBias)),
        .bias_en (state_q == StBias),
        .rnd_en  (state_q == StRound),
        .cdata   (cdata_rd),
        .wdata   (wdata),
        .odata   (odata)
    );

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: hand-computed per-neuron results, strobe timing,
// ignored ready pulses, mid-run reset and restart.
module tb_fc_layer;
    import fc_pkg::*;

    localparam int unsigned NW   = N_OUT * (N_IN + 1);
    localparam int unsigned PER  = N_IN + 3;
    localparam int unsigned BUSY = N_OUT * PER;

    logic           clk = 1'b0;
    logic           reset;
    logic           ready;
    logic           busy;
    logic           crd;
    logic [11:0]    caddr_rd;
    logic [DW-1:0]  cdata_rd;
    logic           wrd;
    logic [WAW-1:0] waddr;
    logic [DW-1:0]  wdata;
    logic           owr;
    logic [3:0]     oaddr;
    logic [DW-1:0]  odata;

    logic [DW-1:0] xmem [N_IN];
    logic [DW-1:0] wmem [NW];
    logic [DW-1:0] exp_res [N_OUT];
    logic [DW-1:0] got_d [N_OUT];
    logic [3:0]    got_a [N_OUT];

    int n_total = 0;
    int n_bad   = 0;
    int busy_cnt;
    int wr_cnt;

    always #5 clk = ~clk;

    assign cdata_rd = xmem[caddr_rd];
    assign wdata    = wmem[waddr];

    fc_layer dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .busy     (busy),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .wrd      (wrd),
        .waddr    (waddr),
        .wdata    (wdata),
        .owr      (owr),
        .oaddr    (oaddr),
        .odata    (odata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Logit vs hidden-layer expectation for a signed result.
    function automatic logic [DW-1:0] act(input logic [DW-1:0] v);
`ifdef FC_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // One clock; sample outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (owr) begin
            if (wr_cnt < int'(N_OUT)) begin
                got_d[wr_cnt] = odata;
                got_a[wr_cnt] = oaddr;
            end
            wr_cnt++;
        end
    endtask

    task automatic start();
        busy_cnt = 0;
        wr_cnt   = 0;
        ready    = 1'b1;
        tick();
        ready    = 1'b0;
    endtask

    // Run to completion; with poke set, pulse ready at points while busy.
    task automatic wait_idle(input bit poke);
        for (int c = 0; c < int'(BUSY) + 100; c++) begin
            if (!busy) break;
            ready = poke && (c == 100 || c == 9000 || c == int'(BUSY) - 2);
            tick();
            ready = 1'b0;
        end
        check("timeout_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_run(input string run);
        check({run, "_busy_width"}, busy_cnt, BUSY);
        check({run, "_owr_count"}, wr_cnt, N_OUT);
        for (int k = 0; k < int'(N_OUT); k++) begin
            check($sformatf("%s_oaddr[%0d]", run, k), 32'(got_a[k]), k);
            check($sformatf("%s_odata[%0d]", run, k), 32'(got_d[k]), 32'(exp_res[k]));
        end
    endtask

    initial begin
        for (int i = 0; i < int'(N_IN); i++) xmem[i] = 20'h10000;
        xmem[5] = 20'h00001;
        for (int i = 0; i < int'(NW); i++) wmem[i] = 20'h00000;
        // n0: 1.0*0.5 + 1/16
        wmem[0*2049 + 0]    = 20'h08000;
        wmem[0*2049 + 2048] = 20'h01000;
        exp_res[0] = 20'h09000;
        // n1: 1.0*-1.0
        wmem[1*2049 + 0] = 20'hF0000;
        exp_res[1] = act(20'hF0000);
        // n2: ~2047.0, positive saturation
        for (int i = 0; i < int'(N_IN); i++) wmem[2*2049 + i] = 20'h10000;
        exp_res[2] = 20'h7FFFF;
        // n3: 2^-16 * 0.5, exact half rounds up
        wmem[3*2049 + 5] = 20'h08000;
        exp_res[3] = 20'h00001;
        // n4: 1.0 - 8.0 = -7.0
        wmem[4*2049 + 1]    = 20'h10000;
        wmem[4*2049 + 2048] = 20'h80000;
        exp_res[4] = act(20'h90000);
        // n5: ~-2047.0, negative saturation
        for (int i = 0; i < int'(N_IN); i++) wmem[5*2049 + i] = 20'hF0000;
        exp_res[5] = act(20'h80000);
        // n6: -0.5 LSB tie rounds toward +inf to 0
        wmem[6*2049 + 5] = 20'hF8000;
        exp_res[6] = 20'h00000;
        // n7: bias only, largest positive
        wmem[7*2049 + 2048] = 20'h7FFFF;
        exp_res[7] = 20'h7FFFF;
        // n8: 2.0 + 3.0
        wmem[8*2049 + 2] = 20'h20000;
        wmem[8*2049 + 3] = 20'h30000;
        exp_res[8] = 20'h50000;
        // n9: bias only, most negative
        wmem[9*2049 + 2048] = 20'h80000;
        exp_res[9] = act(20'h80000);

        busy_cnt = 0;
        wr_cnt   = 0;
        reset    = 1'b1;
        ready    = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_crd", 32'(crd), 0);
        check("rst_wrd", 32'(wrd), 0);
        check("rst_owr", 32'(owr), 0);
        check("rst_caddr", 32'(caddr_rd), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_oaddr", 32'(oaddr), 0);
        check("rst_odata", 32'(odata), 0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        // Run A: full pass with ready pokes while busy.
        start();
        check("a_first_crd", 32'(crd), 1);
        check("a_first_waddr", 32'(waddr), 0);
        wait_idle(1'b1);
        check_run("a");
        repeat (3) tick();
        check("done_busy", 32'(busy), 0);
        check("done_strobes", {29'd0, crd, wrd, owr}, 0);

        // Run B: restart from DONE, reset at neuron 3, i = 1000.
        start();
        for (int c = 0; c < int'(BUSY); c++) begin
            if (busy_cnt >= 3 * int'(PER) + 1000 + 1) break;
            tick();
        end
        check("b_caddr", 32'(caddr_rd), 1000);
        check("b_waddr", 32'(waddr), 3 * 2049 + 1000);
        check("b_oaddr", 32'(oaddr), 3);
        check("b_crd", 32'(crd), 1);
        check("b_writes_before", wr_cnt, 3);
        reset = 1'b1;
        tick();
        check("b_rst_busy", 32'(busy), 0);
        check("b_rst_owr", 32'(owr), 0);
        check("b_rst_crd", 32'(crd), 0);
        check("b_rst_oaddr", 32'(oaddr), 0);
        check("b_rst_odata", 32'(odata), 0);
        check("b_no_partial_write", wr_cnt, 3);
        reset = 1'b0;
        tick();
        check("b_idle_busy", 32'(busy), 0);

        // Run C: fresh start after the abort.
        start();
        wait_idle(1'b0);
        check_run("c");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
